// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_pkg
//  Description : Shared MIDI constants, parser state type and message-length
//                helper used by the input parser and the status decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CTRL     = 4'hB;
    localparam logic [3:0] PRG      = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;
    localparam logic [3:0] SYS      = 4'hF;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } parser_state_t;

    // Number of data bytes that follow a status byte (0 for anything without a fixed payload).
    function automatic logic [1:0] data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        case (status[7:4])
            NOTE_OFF, NOTE_ON, POLY_AT, CTRL, PITCH: len = 2'd2;
            PRG, CH_AT:                              len = 2'd1;
            SYS: begin
                case (status[3:0])
                    4'h1, 4'h3: len = 2'd1;
                    4'h2:       len = 2'd2;
                    default:    len = 2'd0;
                endcase
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : midi_timeout_cnt
//  Description : Saturating cycle counter with synchronous clear and an
//                expiry flag once LIMIT-1 is reached (LIMIT of 0 disables).
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_timeout_cnt
    import midi_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_last = LIMIT - c_one;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + c_one;
        end
    end

    assign expired = (LIMIT != '0) && (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/midi_in_parser.sv
`default_nettype none
// ============================================================================
//  Module      : midi_in_parser
//  Description : Assembles MIDI messages from received bytes with running
//                status, real-time pass-through and sysex payload streaming.
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_in_parser
    import midi_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       reg_clk,
    input  logic       reset,
    input  logic       byte_ready,
    input  logic [7:0] cur_byte,
    output logic [7:0] cur_status,
    output logic [6:0] databyte_1,
    output logic [6:0] databyte_2,
    output logic       msg_valid,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       sysex_active,
    output logic       sysex_valid,
    output logic [6:0] sysex_byte,
    output logic       timeout_err
);

    parser_state_t r_state, w_state_nx;
    logic [7:0] r_status, w_status_nx;
    logic [1:0] r_len, w_len_nx;
    logic [6:0] r_hold, w_hold_nx;
    logic [6:0] r_db1, w_db1_nx;
    logic [6:0] r_db2, w_db2_nx;
    logic       r_msg, w_msg_nx;
    logic       r_rt, w_rt_nx;
    logic [7:0] r_rtb, w_rtb_nx;
    logic       r_sxa, w_sxa_nx;
    logic       r_sxv, w_sxv_nx;
    logic [6:0] r_sxb, w_sxb_nx;
    logic       r_terr, w_terr_nx;
    logic       r_clr_pend, w_clr_nx;
    logic       w_cnt_clear;
    logic       w_cnt_en;
    logic       w_expired;
    logic       w_sys_msg;

    assign w_sys_msg = (r_status[7:4] == SYS);
    assign w_cnt_en  = (r_state == ST_WAIT_D2);

    midi_timeout_cnt #(
        .WIDTH (16),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (reg_clk),
        .rst     (reset),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    always_ff @(posedge reg_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_status   <= 8'h00;
            r_len      <= 2'd0;
            r_hold     <= 7'd0;
            r_db1      <= 7'd0;
            r_db2      <= 7'd0;
            r_msg      <= 1'b0;
            r_rt       <= 1'b0;
            r_rtb      <= 8'h00;
            r_sxa      <= 1'b0;
            r_sxv      <= 1'b0;
            r_sxb      <= 7'd0;
            r_terr     <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_status   <= w_status_nx;
            r_len      <= w_len_nx;
            r_hold     <= w_hold_nx;
            r_db1      <= w_db1_nx;
            r_db2      <= w_db2_nx;
            r_msg      <= w_msg_nx;
            r_rt       <= w_rt_nx;
            r_rtb      <= w_rtb_nx;
            r_sxa      <= w_sxa_nx;
            r_sxv      <= w_sxv_nx;
            r_sxb      <= w_sxb_nx;
            r_terr     <= w_terr_nx;
            r_clr_pend <= w_clr_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        // System-common status is shown with its msg_valid and dropped one cycle later.
        w_status_nx = r_clr_pend ? 8'h00 : r_status;
        w_len_nx    = r_len;
        w_hold_nx   = r_hold;
        w_db1_nx    = r_db1;
        w_db2_nx    = r_db2;
        w_msg_nx    = 1'b0;
        w_rt_nx     = 1'b0;
        w_rtb_nx    = r_rtb;
        w_sxa_nx    = r_sxa;
        w_sxv_nx    = 1'b0;
        w_sxb_nx    = r_sxb;
        w_terr_nx   = 1'b0;
        w_clr_nx    = 1'b0;
        w_cnt_clear = 1'b0;

        if (byte_ready && (cur_byte >= RT_MIN)) begin
            w_rt_nx  = 1'b1;
            w_rtb_nx = cur_byte;
        end else if (byte_ready) begin
            w_cnt_clear = 1'b1;
            if (!cur_byte[7]) begin
                case (r_state)
                    ST_SYSEX: begin
                        w_sxv_nx = 1'b1;
                        w_sxb_nx = cur_byte[6:0];
                    end
                    ST_WAIT_D1: begin
                        if (r_len == 2'd1) begin
                            w_db1_nx   = cur_byte[6:0];
                            w_db2_nx   = 7'd0;
                            w_msg_nx   = 1'b1;
                            w_state_nx = w_sys_msg ? ST_IDLE : ST_WAIT_D1;
                            w_clr_nx   = w_sys_msg;
                        end else begin
                            w_hold_nx  = cur_byte[6:0];
                            w_state_nx = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        w_db1_nx   = r_hold;
                        w_db2_nx   = cur_byte[6:0];
                        w_msg_nx   = 1'b1;
                        w_state_nx = w_sys_msg ? ST_IDLE : ST_WAIT_D1;
                        w_clr_nx   = w_sys_msg;
                    end
                    default: ;
                endcase
            end else if (cur_byte < SYSEX_START) begin
                w_status_nx = cur_byte;
                w_len_nx    = data_len(cur_byte);
                w_state_nx  = ST_WAIT_D1;
                w_sxa_nx    = 1'b0;
            end else begin
                case (cur_byte)
                    SYSEX_START: begin
                        w_status_nx = cur_byte;
                        w_sxa_nx    = 1'b1;
                        w_state_nx  = ST_SYSEX;
                    end
                    SYSEX_END: begin
                        if (r_state == ST_SYSEX) begin
                            w_status_nx = 8'h00;
                            w_sxa_nx    = 1'b0;
                            w_state_nx  = ST_IDLE;
                        end
                    end
                    8'hF1, 8'hF2, 8'hF3: begin
                        w_status_nx = cur_byte;
                        w_len_nx    = data_len(cur_byte);
                        w_state_nx  = ST_WAIT_D1;
                        w_sxa_nx    = 1'b0;
                    end
                    8'hF6: begin
                        w_status_nx = cur_byte;
                        w_db1_nx    = 7'd0;
                        w_db2_nx    = 7'd0;
                        w_msg_nx    = 1'b1;
                        w_clr_nx    = 1'b1;
                        w_state_nx  = ST_IDLE;
                        w_sxa_nx    = 1'b0;
                    end
                    default: ;
                endcase
            end
        end else if ((r_state == ST_WAIT_D2) && w_expired) begin
            w_terr_nx  = 1'b1;
            w_state_nx = ST_WAIT_D1;
        end
    end

    assign cur_status   = r_status;
    assign databyte_1   = r_db1;
    assign databyte_2   = r_db2;
    assign msg_valid    = r_msg;
    assign rt_valid     = r_rt;
    assign rt_byte      = r_rtb;
    assign sysex_active = r_sxa;
    assign sysex_valid  = r_sxv;
    assign sysex_byte   = r_sxb;
    assign timeout_err  = r_terr;

endmodule
`default_nettype wire

// File: doc/midi_in_parser.md
Name: midi_in_parser

Overview:
- Byte-level MIDI message assembler between the UART receiver and the status decoder / synth controller.
- Takes a strobed stream of received bytes and tracks running status.
- Assembles channel-voice and system-common messages; emits cur_status plus data bytes with a one-cycle message strobe.
- Passes real-time bytes and sysex payload through on separate strobes. Its cur_status output drives the status-decode stage.

Parameters:
- TIMEOUT_CYCLES, 16'd50000: reg_clk cycles a partially received message may stay incomplete before its data bytes are discarded. 0 disables the timeout.

Ports:
- reg_clk  in  1  system register clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- byte_ready  in  1  one-cycle strobe: cur_byte valid
- cur_byte  in  8  received MIDI byte
- cur_status  out  8  current (running) status byte; 8'h00 = none
- databyte_1  out  7  first data byte of the last completed message
- databyte_2  out  7  second data byte; 0 for 1-byte messages
- msg_valid  out  1  one-cycle pulse: complete message on cur_status/databyte_*
- rt_valid  out  1  one-cycle pulse: real-time byte on rt_byte
- rt_byte  out  8  last real-time byte (F8-FF)
- sysex_active  out  1  high between F0 and its terminator
- sysex_valid  out  1  one-cycle pulse: sysex payload byte on sysex_byte
- sysex_byte  out  7  sysex payload byte
- timeout_err  out  1  one-cycle pulse when a partial message is discarded

Behaviour:
- Reset: every output 0; cur_status 8'h00; state IDLE; timeout counter 0.
- All outputs registered. Input bytes are processed only when byte_ready=1; byte_ready back-to-back on consecutive cycles must be accepted.
- Latency: msg_valid, rt_valid and sysex_valid assert on the cycle after the byte_ready that completes them.
- Byte classes:
  - Real-time (F8-FF): rt_byte<=cur_byte, rt_valid=1. No change to state, counters, cur_status or sysex_active. Legal mid-message and mid-sysex.
  - Status (80-EF): cur_status<=byte; needed = 2 for 8x,9x,Ax,Bx,Ex and 1 for Cx,Dx; go to WAIT_D1. Ends an active sysex (sysex_active<=0). Discards any partial message silently.
  - F0: cur_status<=F0, sysex_active<=1, state SYSEX.
  - F7: in SYSEX, sysex_active<=0, cur_status<=8'h00, state IDLE. Outside SYSEX, ignored.
  - F1, F3: needed=1. F2: needed=2. F6: msg_valid immediately with data 0. F4/F5: ignored.
  - In all system-common cases the running status is cleared after completion: cur_status returns to 8'h00 on the cycle after msg_valid. System common also ends sysex.
  - Data byte (00-7F):
    - IDLE: dropped.
    - SYSEX: sysex_byte<=byte[6:0], sysex_valid=1.
    - WAIT_D1: latch into a hold register. If needed=1, publish databyte_1, databyte_2=0, msg_valid=1, return to WAIT_D1 (running status kept). Else go to WAIT_D2.
    - WAIT_D2: publish both bytes, msg_valid=1, return to WAIT_D1.
- databyte_1/databyte_2 change only together with msg_valid and hold between messages.
- States: IDLE, WAIT_D1, WAIT_D2, SYSEX.
- Timeout:
  - Counter counts reg_clk cycles while in WAIT_D2. It resets on every accepted non-real-time byte.
  - On reaching TIMEOUT_CYCLES-1: timeout_err=1 for one cycle, state WAIT_D1, cur_status kept.
  - Counter saturates and never wraps. Real-time bytes do not reset it.
- Simultaneous events: only one byte per cycle by construction; a timeout expiry coinciding with byte_ready processes the byte instead of the timeout.
- Reset mid-message or mid-sysex: everything returns to reset values next cycle and no strobe is emitted.

Decomposition:
- Shared package midi_pkg:
  - Status nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CTRL=B, PRG=C, CH_AT=D, PITCH=E, SYS=F).
  - SYSEX_START=F0, SYSEX_END=F7, RT_MIN=F8.
  - Parser state enum.
  - Function data_len(status) returning 0/1/2, reused by the downstream decoder.
- One natural sub-module: midi_timeout_cnt (saturating counter with clear/enable/expire).

Test Plan:
- Send 90 3C 64 -> one msg_valid with cur_status=90, databyte_1=3C, databyte_2=64. Then send 3E 00 -> second msg_valid with cur_status=90, databyte_1=3E, databyte_2=00 (running status).
- Send C5 07 -> msg_valid with databyte_1=07, databyte_2=00. Then 09 -> msg_valid with databyte_1=09.
- Send B0 F8 07 F8 7F -> two rt_valid pulses with rt_byte=F8, and one msg_valid with B0/07/7F.
- Send F0 43 10 F7 -> sysex_active high from F0 to F7, two sysex_valid pulses (43, 10), then cur_status=00. A following 40 is dropped.
- With TIMEOUT_CYCLES=8, send 90 3C then idle 8 cycles -> timeout_err pulse, no msg_valid. Then send 40 50 -> msg_valid with 90/40/50.
- Assert reset after 80 3C -> all outputs 0 next cycle. Then send 50 -> no msg_valid.
